rom_access_arbiter: RTL

//   Shares the single-port program ROM between instruction fetch (IF) and data load (LD) requesters.

---
 rtl/rom_access_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rom_access_arbiter.sv
// Shares the single-port program ROM between the IF and LD requesters, one access at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise IF has fixed priority over LD.
module rom_access_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROM_WORDS  = 2048
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic                  if_err_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  ld_req_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    output logic                  ld_gnt_o,
    output logic                  ld_rvalid_o,
    output logic                  ld_err_o,
    output logic [DATA_WIDTH-1:0] ld_rdata_o,
    output logic                  rom_en_n_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i
);

    localparam int unsigned RANGE_LSB = $clog2(ROM_WORDS) + 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0]            r_state;
    logic                  r_owner_ld;
    logic                  r_err;
    logic                  r_rom_en_n;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic                  r_if_gnt;
    logic                  r_if_rvalid;
    logic                  r_if_err;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic                  r_ld_gnt;
    logic                  r_ld_rvalid;
    logic                  r_ld_err;
    logic [DATA_WIDTH-1:0] r_ld_rdata;

    logic [1:0]            w_state_nxt;
    logic                  w_owner_ld_nxt;
    logic                  w_err_nxt;
    logic                  w_rom_en_n_nxt;
    logic [ADDR_WIDTH-1:0] w_rom_addr_nxt;
    logic                  w_if_gnt_nxt;
    logic                  w_if_rvalid_nxt;
    logic                  w_if_err_nxt;
    logic [DATA_WIDTH-1:0] w_if_rdata_nxt;
    logic                  w_ld_gnt_nxt;
    logic                  w_ld_rvalid_nxt;
    logic                  w_ld_err_nxt;
    logic [DATA_WIDTH-1:0] w_ld_rdata_nxt;

    logic                  w_any_req;
    logic                  w_win_ld;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic                  w_oor;
    logic [DATA_WIDTH-1:0] w_resp_data;

    assign w_any_req = if_req_i | ld_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    // r_rr_ld remembers whether LD won the last grant; on a tie the other side wins
    logic r_rr_ld;

    assign w_win_ld = ld_req_i & (~if_req_i | ~r_rr_ld);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ld <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_rr_ld <= w_win_ld;
        end
    end
`else
    assign w_win_ld = ld_req_i & ~if_req_i;
`endif

    assign w_win_addr  = w_win_ld ? ld_addr_i : if_addr_i;
    assign w_oor       = |w_win_addr[ADDR_WIDTH-1:RANGE_LSB];
    assign w_resp_data = r_err ? '0 : rom_data_i;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_ld_nxt  = r_owner_ld;
        w_err_nxt       = r_err;
        w_rom_en_n_nxt  = 1'b1;
        w_rom_addr_nxt  = r_rom_addr;
        w_if_gnt_nxt    = 1'b0;
        w_if_rvalid_nxt = 1'b0;
        w_if_err_nxt    = r_if_err;
        w_if_rdata_nxt  = r_if_rdata;
        w_ld_gnt_nxt    = 1'b0;
        w_ld_rvalid_nxt = 1'b0;
        w_ld_err_nxt    = r_ld_err;
        w_ld_rdata_nxt  = r_ld_rdata;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_owner_ld_nxt = w_win_ld;
                    w_err_nxt      = w_oor;
                    w_if_gnt_nxt   = ~w_win_ld;
                    w_ld_gnt_nxt   = w_win_ld;
                    if (!w_oor) begin
                        w_rom_en_n_nxt = 1'b0;
                        w_rom_addr_nxt = w_win_addr;
                    end
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (r_owner_ld) begin
                    w_ld_rvalid_nxt = 1'b1;
                    w_ld_err_nxt    = r_err;
                    w_ld_rdata_nxt  = w_resp_data;
                end else begin
                    w_if_rvalid_nxt = 1'b1;
                    w_if_err_nxt    = r_err;
                    w_if_rdata_nxt  = w_resp_data;
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_owner_ld  <= 1'b0;
            r_err       <= 1'b0;
            r_rom_en_n  <= 1'b1;
            r_rom_addr  <= '0;
            r_if_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_ld_gnt    <= 1'b0;
            r_ld_rvalid <= 1'b0;
            r_ld_err    <= 1'b0;
            r_ld_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner_ld  <= w_owner_ld_nxt;
            r_err       <= w_err_nxt;
            r_rom_en_n  <= w_rom_en_n_nxt;
            r_rom_addr  <= w_rom_addr_nxt;
            r_if_gnt    <= w_if_gnt_nxt;
            r_if_rvalid <= w_if_rvalid_nxt;
            r_if_err    <= w_if_err_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_ld_gnt    <= w_ld_gnt_nxt;
            r_ld_rvalid <= w_ld_rvalid_nxt;
            r_ld_err    <= w_ld_err_nxt;
            r_ld_rdata  <= w_ld_rdata_nxt;
        end
    end

    assign if_gnt_o    = r_if_gnt;
    assign if_rvalid_o = r_if_rvalid;
    assign if_err_o    = r_if_err;
    assign if_rdata_o  = r_if_rdata;
    assign ld_gnt_o    = r_ld_gnt;
    assign ld_rvalid_o = r_ld_rvalid;
    assign ld_err_o    = r_ld_err;
    assign ld_rdata_o  = r_ld_rdata;
    assign rom_en_n_o  = r_rom_en_n;
    assign rom_addr_o  = r_rom_addr;

endmodule
